// File: rtl/d_flip_flop.sv
// Rising-edge D register with active-high load enable and synchronous active-low reset.
// q comes straight from the storage flop; reset wins over en and d.
module d_flip_flop #(
   parameter int unsigned          WIDTH       = 1,
   parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = d;
      end
   end

   // Reset is sampled only at the edge, so pulses between edges are ignored.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q_q <= RESET_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Bench for d_flip_flop: a 1-bit default instance and an 8-bit instance with reset
// value A5 share stimulus; expected values go through a scoreboard queue.
module tb_d_flip_flop;

   logic       clk;
   logic       reset;
   logic       en;
   logic       d1;
   logic [7:0] d8;
   logic       q1;
   logic [7:0] q8;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic       rst;
      logic       en;
      logic       d1;
      logic [7:0] d8;
      logic       e1;
      logic [7:0] e8;
   } vec_t;

   typedef struct {
      string      name;
      logic       e1;
      logic [7:0] e8;
   } exp_t;

   vec_t vecs[15];
   exp_t sb[$];

   d_flip_flop u_dut1 (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (d1),
      .q     (q1)
   );

   d_flip_flop #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (d8),
      .q     (q8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Drive on the falling edge and queue what the next rising edge must produce.
   task automatic drive(input string nm, input logic r, input logic e, input logic v1,
                        input logic [7:0] v8, input logic x1, input logic [7:0] x8);
      exp_t ex;
      @(negedge clk);
      reset = r;
      en    = e;
      d1    = v1;
      d8    = v8;
      ex.name = nm;
      ex.e1   = x1;
      ex.e8   = x8;
      sb.push_back(ex);
   endtask

   task automatic check_edge();
      exp_t ex;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         ex = sb.pop_front();
         cmp({ex.name, "_q1"}, {7'd0, q1}, {7'd0, ex.e1});
         cmp({ex.name, "_q8"}, q8, ex.e8);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      en    = 1'b0;
      d1    = 1'b0;
      d8    = 8'h00;

      //           rst   en    d1    d8     q1    q8
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hA5};  // reset beats en/d
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hA5};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C};  // release: follow d
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'h11};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11};  // hold x3
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h11};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 8'h77};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8'hA5};  // reset priority, en=1
      vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'hA5};  // reset priority, en=0
      vecs[13] = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C};  // width hold

      foreach (vecs[i]) begin
         drive($sformatf("vec%0d", i), vecs[i].rst, vecs[i].en, vecs[i].d1, vecs[i].d8,
               vecs[i].e1, vecs[i].e8);
         check_edge();
      end

      // Reset pulse that does not span an edge must be ignored (q = 1 / 3C).
      @(negedge clk);
      en = 1'b0;
      #1 reset = 1'b0;
      #3 reset = 1'b1;
      cmp("pulse_mid_q1", {7'd0, q1}, 8'h01);
      cmp("pulse_mid_q8", q8, 8'h3C);
      sb.push_back('{"pulse_edge", 1'b1, 8'h3C});
      check_edge();

      // d changed mid-cycle: no effect until the edge.
      @(negedge clk);
      en = 1'b1;
      d1 = 1'b0;
      d8 = 8'hC3;
      #2;
      cmp("dmid_q1", {7'd0, q1}, 8'h01);
      cmp("dmid_q8", q8, 8'h3C);
      sb.push_back('{"dmid_edge", 1'b0, 8'hC3});
      check_edge();

      // Reset asserted between edges: q unchanged until the edge, then reset value.
      @(negedge clk);
      d1 = 1'b1;
      d8 = 8'h5A;
      reset = 1'b0;
      #3;
      cmp("rstmid_q1", {7'd0, q1}, 8'h00);
      cmp("rstmid_q8", q8, 8'hC3);
      sb.push_back('{"rstmid_edge", 1'b0, 8'hA5});
      check_edge();

      // Release: normal loading resumes at the very next edge.
      drive("release", 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A);
      check_edge();

      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
